// File: rtl/cpu_pkg.sv
// cpu_pkg: shared sizing for the ALU write-back stage (acc_flag_wb / flag_lifo).
//   DWIDTH_DEF  : default datapath width, matches the ALU
//   DEPTH_DEF   : default number of context-save LIFO entries
//   FLAG_BITS   : flag bits stored with ACC in each LIFO entry
//   entry_w()   : LIFO entry width for a given data width
//   sp_w()      : stack-pointer width able to hold 0..depth
// Optional feature macro: ACC_ZERO_FLAG_EN (adds ZF to each LIFO entry).
package cpu_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int DEPTH_DEF  = 4;

`ifdef ACC_ZERO_FLAG_EN
  localparam int FLAG_BITS = 3;   // {ZF, C, B}
`else
  localparam int FLAG_BITS = 2;   // {C, B}
`endif

  localparam int ENTRY_W_DEF = DWIDTH_DEF + FLAG_BITS;

  function automatic int entry_w(input int dwidth);
    return dwidth + FLAG_BITS;
  endfunction

  function automatic int sp_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flag_lifo.sv
// flag_lifo: small LIFO holding arithmetic-context snapshots.
// Ports:
//   CLK, RST   : clock, asynchronous active-high reset
//   push, pop  : requests; a simultaneous push+pop is a no-op
//   wr_data    : snapshot to save on a valid push
//   push_ok    : push accepted this cycle (not full, no pop)
//   pop_ok     : pop accepted this cycle (not empty, no push)
//   rd_data    : top-of-stack entry (entry SP-1), valid whenever pop_ok
//   empty/full : registered, updated on the same edge as SP
//   err_pulse  : single-cycle overflow/underflow indication
// Optional feature macro: ACC_ZERO_FLAG_EN (only affects EWIDTH via cpu_pkg).
module flag_lifo
  import cpu_pkg::*;
#(
  parameter int EWIDTH = ENTRY_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [EWIDTH-1:0] wr_data,
  output logic              push_ok,
  output logic              pop_ok,
  output logic [EWIDTH-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic              err_pulse
);

  localparam int SPW = sp_w(DEPTH);
  localparam int AW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  logic [EWIDTH-1:0] mem [DEPTH];

  logic [SPW-1:0] sp_reg;
  logic [SPW-1:0] sp_next;
  logic [SPW-1:0] sp_dec;
  logic           empty_reg;
  logic           full_reg;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;

  always_comb begin
    push_ok   = push & ~pop & ~full_reg;
    pop_ok    = pop & ~push & ~empty_reg;
    err_pulse = (push & ~pop & full_reg) | (pop & ~push & empty_reg);

    sp_dec = sp_reg - SP_ONE;
    // SP only ranges 0..DEPTH; the low AW bits address the array. When SP is
    // full no write happens, and when SP is zero rd_data is never consumed.
    wr_idx = sp_reg[AW-1:0];
    rd_idx = sp_dec[AW-1:0];

    sp_next = sp_reg;
    if (push_ok) begin
      sp_next = sp_reg + SP_ONE;
    end else if (pop_ok) begin
      sp_next = sp_dec;
    end
  end

  // Read must be combinational: a pop restores ACC/flags on the same edge.
  assign rd_data = mem[rd_idx];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sp_reg    <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      sp_reg    <= sp_next;
      empty_reg <= (sp_next == '0);
      full_reg  <= (sp_next == SP_MAX);
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge CLK) begin
    if (push_ok && !RST) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign empty = empty_reg;
  assign full  = full_reg;

endmodule

// File: rtl/acc_flag_wb.sv
// acc_flag_wb: write-back stage after the ALU. Holds ACC and the C/B flags
// (fed back to the ALU as carry-in/borrow-in) and a LIFO of {C, B, ACC}
// snapshots for one-cycle context save/restore.
// Ports:
//   CLK, RST           : clock, asynchronous active-high reset
//   IN_RES             : ALU result, written on WE
//   IN_COUT/IN_BOUT    : ALU carry/borrow out
//   IN_EN_C/IN_EN_B    : flag-valid qualifiers for a WE cycle
//   IN_DATA            : direct-load data, written on LD
//   WE, LD, CLR_F      : write result, load data, clear flags
//   PUSH, POP          : save / restore context
//   ACC, CIN, BIN      : registered accumulator and flags
//   EMPTY, FULL        : LIFO occupancy
//   ERR                : sticky overflow/underflow, cleared only by RST
//   ZF                 : (ACC_ZERO_FLAG_EN only) registered zero flag
// Optional feature macro: ACC_ZERO_FLAG_EN.
// ACC source priority: valid POP > LD > WE > hold.
module acc_flag_wb
  import cpu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DWIDTH-1:0] IN_RES,
  input  logic              IN_COUT,
  input  logic              IN_BOUT,
  input  logic              IN_EN_C,
  input  logic              IN_EN_B,
  input  logic [DWIDTH-1:0] IN_DATA,
  input  logic              WE,
  input  logic              LD,
  input  logic              CLR_F,
  input  logic              PUSH,
  input  logic              POP,
  output logic [DWIDTH-1:0] ACC,
  output logic              CIN,
  output logic              BIN,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ERR
`ifdef ACC_ZERO_FLAG_EN
  ,
  output logic              ZF
`endif
);

  localparam int EW = entry_w(DWIDTH);

  logic [DWIDTH-1:0] acc_reg, acc_next;
  logic              c_reg, c_next;
  logic              b_reg, b_next;
  logic              err_reg, err_next;

  logic              push_ok, pop_ok, err_pulse;
  logic [EW-1:0]     wr_entry, rd_entry;

`ifdef ACC_ZERO_FLAG_EN
  logic              zf_reg, zf_next;
  assign wr_entry = {zf_reg, c_reg, b_reg, acc_reg};
`else
  assign wr_entry = {c_reg, b_reg, acc_reg};
`endif

  flag_lifo #(
    .EWIDTH (EW),
    .DEPTH  (DEPTH)
  ) u_lifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (PUSH),
    .pop       (POP),
    .wr_data   (wr_entry),
    .push_ok   (push_ok),
    .pop_ok    (pop_ok),
    .rd_data   (rd_entry),
    .empty     (EMPTY),
    .full      (FULL),
    .err_pulse (err_pulse)
  );

  always_comb begin
    acc_next = acc_reg;
    c_next   = c_reg;
    b_next   = b_reg;
    err_next = err_reg | err_pulse;
`ifdef ACC_ZERO_FLAG_EN
    zf_next  = zf_reg;
`endif

    if (pop_ok) begin
      // Restore overrides WE, LD and CLR_F.
      acc_next = rd_entry[DWIDTH-1:0];
      b_next   = rd_entry[DWIDTH];
      c_next   = rd_entry[DWIDTH+1];
`ifdef ACC_ZERO_FLAG_EN
      zf_next  = rd_entry[DWIDTH+2];
`endif
    end else begin
      if (LD) begin
        acc_next = IN_DATA;       // LD never touches flags; IN_RES dropped
      end else if (WE) begin
        acc_next = IN_RES;
        if (IN_EN_C) c_next = IN_COUT;
        if (IN_EN_B) b_next = IN_BOUT;
      end
      if (CLR_F) begin
        c_next = 1'b0;
        b_next = 1'b0;
      end
`ifdef ACC_ZERO_FLAG_EN
      if (LD || WE) zf_next = (acc_next == '0);
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc_reg <= '0;
      c_reg   <= 1'b0;
      b_reg   <= 1'b0;
      err_reg <= 1'b0;
`ifdef ACC_ZERO_FLAG_EN
      zf_reg  <= 1'b1;
`endif
    end else begin
      acc_reg <= acc_next;
      c_reg   <= c_next;
      b_reg   <= b_next;
      err_reg <= err_next;
`ifdef ACC_ZERO_FLAG_EN
      zf_reg  <= zf_next;
`endif
    end
  end

  assign ACC = acc_reg;
  assign CIN = c_reg;
  assign BIN = b_reg;
  assign ERR = err_reg;
`ifdef ACC_ZERO_FLAG_EN
  assign ZF  = zf_reg;
`endif

endmodule

// File: tb/tb_acc_flag_wb.sv
// Testbench for acc_flag_wb (DWIDTH=8, DEPTH=4). Directed vectors push
// hand-computed expected outputs into a scoreboard queue; a monitor pops and
// compares one entry after each rising edge that follows a pushed vector.
// Honours ACC_ZERO_FLAG_EN when defined.
module tb_acc_flag_wb;

  typedef struct packed {
    logic [7:0] acc;
    logic       c;
    logic       b;
    logic       empty;
    logic       full;
    logic       err;
    logic       zf;
  } obs_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] IN_RES = '0, IN_DATA = '0;
  logic       IN_COUT = 0, IN_BOUT = 0, IN_EN_C = 0, IN_EN_B = 0;
  logic       WE = 0, LD = 0, CLR_F = 0, PUSH = 0, POP = 0;
  logic [7:0] acc;
  logic       cin, bin, empty, full, err;
  logic       zf;

  int tests = 0;
  int fails = 0;

  obs_t  exp_q[$];
  string name_q[$];

  always #5 CLK = ~CLK;

  acc_flag_wb #(.DWIDTH(8), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .IN_RES(IN_RES), .IN_COUT(IN_COUT), .IN_BOUT(IN_BOUT),
    .IN_EN_C(IN_EN_C), .IN_EN_B(IN_EN_B), .IN_DATA(IN_DATA),
    .WE(WE), .LD(LD), .CLR_F(CLR_F), .PUSH(PUSH), .POP(POP),
    .ACC(acc), .CIN(cin), .BIN(bin), .EMPTY(empty), .FULL(full), .ERR(err)
`ifdef ACC_ZERO_FLAG_EN
    , .ZF(zf)
`endif
  );

  function automatic obs_t observe();
    obs_t o;
    o.acc = acc; o.c = cin; o.b = bin;
    o.empty = empty; o.full = full; o.err = err;
`ifdef ACC_ZERO_FLAG_EN
    o.zf = zf;
`else
    o.zf = 1'b0;
`endif
    return o;
  endfunction

  task automatic check(input string name, input obs_t e_in);
    obs_t a, e;
    e = e_in;
`ifndef ACC_ZERO_FLAG_EN
    e.zf = 1'b0;
`endif
    a = observe();
    tests++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s: got acc=%h c=%b b=%b empty=%b full=%b err=%b zf=%b, expected acc=%h c=%b b=%b empty=%b full=%b err=%b zf=%b",
               name, a.acc, a.c, a.b, a.empty, a.full, a.err, a.zf,
               e.acc, e.c, e.b, e.empty, e.full, e.err, e.zf);
    end else begin
      $display("[TB] %s ok: acc=%h c=%b b=%b empty=%b full=%b err=%b zf=%b",
               name, a.acc, a.c, a.b, a.empty, a.full, a.err, a.zf);
    end
  endtask

  // Monitor: outputs settle one edge after a vector is applied.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        check(name_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  task automatic clr_in();
    IN_RES = '0; IN_DATA = '0; IN_COUT = 0; IN_BOUT = 0;
    IN_EN_C = 0; IN_EN_B = 0; WE = 0; LD = 0; CLR_F = 0; PUSH = 0; POP = 0;
  endtask

  // Queue the expectation for the inputs already driven, then advance.
  task automatic cyc(input string name, input logic [7:0] e_acc,
                     input logic e_c, input logic e_b, input logic e_empty,
                     input logic e_full, input logic e_err, input logic e_zf);
    exp_q.push_back('{e_acc, e_c, e_b, e_empty, e_full, e_err, e_zf});
    name_q.push_back(name);
    @(negedge CLK);
    clr_in();
  endtask

  initial begin
    clr_in();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("reset_state", '{8'h00, 0, 0, 1, 0, 0, 1});

    // Write-back and flag qualifiers
    WE = 1; IN_RES = 8'h00; IN_COUT = 1; IN_EN_C = 1;
    cyc("we_add_cout",   8'h00, 1, 0, 1, 0, 0, 1);
    WE = 1; IN_RES = 8'h00; IN_COUT = 0; IN_EN_C = 0;
    cyc("cin_hold",      8'h00, 1, 0, 1, 0, 0, 1);
    // Priority
    LD = 1; WE = 1; IN_DATA = 8'h70; IN_RES = 8'h20;
    IN_EN_C = 1; IN_COUT = 0; IN_EN_B = 1; IN_BOUT = 1;
    cyc("ld_over_we",    8'h70, 1, 0, 1, 0, 0, 0);
    WE = 1; CLR_F = 1; IN_RES = 8'h33; IN_EN_B = 1; IN_BOUT = 1; IN_EN_C = 1; IN_COUT = 1;
    cyc("clrf_over_we",  8'h33, 0, 0, 1, 0, 0, 0);
    POP = 1; WE = 1; IN_RES = 8'h5A; IN_COUT = 1; IN_EN_C = 1;
    cyc("pop_empty_we",  8'h5A, 1, 0, 1, 0, 1, 0);

    // Asynchronous reset mid-run: visible before the next edge
    RST = 1'b1;
    #1;
    check("async_reset", '{8'h00, 0, 0, 1, 0, 0, 1});
    @(negedge CLK);
    RST = 1'b0;

    // LIFO round trip
    WE = 1; IN_RES = 8'h11; IN_COUT = 1; IN_EN_C = 1;
    cyc("set_11",        8'h11, 1, 0, 1, 0, 0, 0);
    PUSH = 1; LD = 1; IN_DATA = 8'h22;
    cyc("push_11_ld22",  8'h22, 1, 0, 0, 0, 0, 0);
    WE = 1; IN_RES = 8'h22; IN_EN_B = 1; IN_BOUT = 1; IN_EN_C = 1; IN_COUT = 0;
    cyc("set_b",         8'h22, 0, 1, 0, 0, 0, 0);
    PUSH = 1;
    cyc("push_22",       8'h22, 0, 1, 0, 0, 0, 0);
    LD = 1; IN_DATA = 8'hFF;
    cyc("ovw_ff",        8'hFF, 0, 1, 0, 0, 0, 0);
    CLR_F = 1;
    cyc("clr_flags",     8'hFF, 0, 0, 0, 0, 0, 0);
    POP = 1; WE = 1; IN_RES = 8'h99; CLR_F = 1;
    cyc("pop_22",        8'h22, 0, 1, 0, 0, 0, 0);
    POP = 1;
    cyc("pop_11",        8'h11, 1, 0, 1, 0, 0, 0);

    // Zero flag save/restore
    LD = 1; IN_DATA = 8'h00;
    cyc("ld_00",         8'h00, 1, 0, 1, 0, 0, 1);
    PUSH = 1; WE = 1; IN_RES = 8'h01;
    cyc("push_z_we01",   8'h01, 1, 0, 0, 0, 0, 0);
    POP = 1;
    cyc("pop_z",         8'h00, 1, 0, 1, 0, 0, 1);

    // Fill to DEPTH, then overflow
    PUSH = 1; LD = 1; IN_DATA = 8'hA1;
    cyc("fill_1",        8'hA1, 1, 0, 0, 0, 0, 0);
    PUSH = 1; LD = 1; IN_DATA = 8'hA2;
    cyc("fill_2",        8'hA2, 1, 0, 0, 0, 0, 0);
    PUSH = 1; LD = 1; IN_DATA = 8'hA3;
    cyc("fill_3",        8'hA3, 1, 0, 0, 0, 0, 0);
    PUSH = 1; LD = 1; IN_DATA = 8'hA4;
    cyc("fill_4_full",   8'hA4, 1, 0, 0, 1, 0, 0);
    PUSH = 1; LD = 1; IN_DATA = 8'hA5;
    cyc("push_overflow", 8'hA5, 1, 0, 0, 1, 1, 0);
    PUSH = 1; POP = 1; WE = 1; IN_RES = 8'hB0;
    cyc("push_pop_full", 8'hB0, 1, 0, 0, 1, 1, 0);
    POP = 1;
    cyc("drain_a3",      8'hA3, 1, 0, 0, 0, 1, 0);
    POP = 1;
    cyc("drain_a2",      8'hA2, 1, 0, 0, 0, 1, 0);
    POP = 1;
    cyc("drain_a1",      8'hA1, 1, 0, 0, 0, 1, 0);
    POP = 1;
    cyc("drain_00",      8'h00, 1, 0, 1, 0, 1, 1);
    POP = 1; WE = 1; IN_RES = 8'h03;
    cyc("pop_empty_03",  8'h03, 1, 0, 1, 0, 1, 0);
    PUSH = 1; POP = 1; LD = 1; IN_DATA = 8'h44;
    cyc("push_pop_empty",8'h44, 1, 0, 1, 0, 1, 0);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
